mega_jsoc_mem_copy_master: RTL and testbench
============================================

# mega_jsoc_mem_copy_master

Avalon-MM pipelined master that copies a block of 32-bit words from a source region to a destination region. Typical targets are on-chip memory slaves such as the Mega_JSoC on-chip RAMs. It sits on the system interconnect next to the processor, which drives its start/address/length inputs through a small PIO or CSR wrapper. One word is in flight at a time: read, then write, then advance.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the Avalon master port.
- LEN_W, 16, width of the word-count input and the progress counter.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; bits [1:0] are ignored (treated as 0).
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] are ignored.
- len_words  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high in RD_REQ, RD_WAIT and WR_REQ.
- done  out  1  one-cycle pulse when a copy completes.
- words_done  out  LEN_W  words written so far in the current or last copy.
- avm_address  out  ADDR_W  word-aligned byte address.
- avm_read  out  1  read strobe.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'b1111.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE with start=1 and len_words≠0:
  - latch src, dst and len; clear words_done;
  - go to RD_REQ.
- IDLE with start=1 and len_words=0:
  - go to DONE with no bus traffic;
  - words_done is cleared to 0.
- RD_REQ:
  - drive avm_read=1 and avm_address=src_cur;
  - hold both stable while avm_waitrequest=1;
  - on waitrequest=0, go to RD_WAIT.
- RD_WAIT:
  - strobes are low;
  - on avm_readdatavalid=1, capture avm_readdata into the data register and go to WR_REQ;
  - the fabric guarantees readdatavalid arrives at least 1 cycle after accept, so readdatavalid is ignored in every other state.
- WR_REQ:
  - drive avm_write=1, avm_address=dst_cur and avm_writedata=the data register; hold while waitrequest=1.
  - On accept: src_cur+=4, dst_cur+=4, words_done+=1.
  - If words_done+1 = len, go to DONE; otherwise go to RD_REQ.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while not IDLE is ignored; the latched parameters never change mid-copy.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top address is allowed, not flagged.
- Source and destination overlap is not detected; the copy proceeds in ascending order.
- avm_read and avm_write are never high in the same cycle.
- Reset (reset_n low, any time, including with a strobe pending):
  - immediately forces IDLE;
  - avm_read=0, avm_write=0, done=0, busy=0;
  - words_done=0, avm_address=0, avm_writedata=0.
  - A read accepted before reset whose readdatavalid arrives after reset is discarded.

## Timing
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Cycle 0: start=1 in IDLE. Cycle 1: avm_read asserted.
- With zero wait states and read latency 1, each word takes 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
  - done pulses at cycle 3N+1 for N words.
  - For len=0, done pulses at cycle 1.
- Each waitrequest cycle adds one cycle; each extra read-latency cycle adds one cycle.
- busy falls in the cycle done rises. A new start is accepted in the cycle after done (IDLE).
- words_done updates in the cycle after the write is accepted.

## Test plan
- Basic copy: memory model with latency 1 and no waitrequest; src=0x0000, dst=0x1000, len=4, source words 0xA0..0xA3.
  - Required: dst holds 0xA0..0xA3; done pulses at cycle 13; words_done=4; exactly 4 reads and 4 writes.
- Zero length: len=0.
  - Required: done at cycle 1; no avm_read or avm_write ever asserted; words_done=0.
- Backpressure: random waitrequest (~50%) and read latency 1–3; len=16.
  - Required: data is correct; address, data and strobe stay stable throughout every stall.
  - Required: read and write are never high together.
- Unaligned and wrap: src=0xFFFF_FFFE (treated as 0xFFFF_FFFC), len=2.
  - Required: reads at 0xFFFF_FFFC then 0x0000_0000.
- Start ignored: pulse start with new parameters during a copy.
  - Required: the original copy completes unchanged; no second copy begins.
- Mid-operation reset: assert reset_n=0 during WR_REQ of word 2 of 8; release, then start a len=1 copy.
  - Required: all outputs go to their reset values immediately; the second copy completes with words_done=1.

Source files
------------

// File: rtl/mega_jsoc_mem_copy_master.sv
// rtl/mega_jsoc_mem_copy_master.sv - Avalon-MM word copy master, one word in flight
module mega_jsoc_mem_copy_master #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len_words,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  words_done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   // Clears the byte-offset bits so every bus address is word aligned.
   localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_words;
   logic [31:0]       r_data;
   logic [LEN_W-1:0]  w_words_inc;
   logic              w_last;

   assign w_words_inc = r_words + LEN_W'(1);
   assign w_last      = (w_words_inc == r_len);

   // Next-state decode; start is only looked at in IDLE so a copy cannot be disturbed.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (len_words == '0) ? S_DONE : S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (!avm_waitrequest) begin
               w_next = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (avm_readdatavalid) begin
               w_next = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (!avm_waitrequest) begin
               w_next = w_last ? S_DONE : S_RD_REQ;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State, latched copy parameters, progress counter and the word being moved.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_len   <= '0;
         r_words <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_words <= '0;
                  if (len_words != '0) begin
                     r_src <= src_addr & WORD_MASK;
                     r_dst <= dst_addr & WORD_MASK;
                     r_len <= len_words;
                  end
               end
            end
            S_RD_WAIT: begin
               if (avm_readdatavalid) begin
                  r_data <= avm_readdata;
               end
            end
            S_WR_REQ: begin
               if (!avm_waitrequest) begin
                  r_src   <= r_src + ADDR_W'(4);
                  r_dst   <= r_dst + ADDR_W'(4);
                  r_words <= w_words_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Bus and status outputs are pure decodes of registered state, so no input reaches an output.
   always_comb begin
      avm_read       = (r_state == S_RD_REQ);
      avm_write      = (r_state == S_WR_REQ);
      avm_address    = '0;
      if (r_state == S_RD_REQ) begin
         avm_address = r_src;
      end else if (r_state == S_WR_REQ) begin
         avm_address = r_dst;
      end
      avm_writedata  = r_data;
      avm_byteenable = 4'b1111;
      busy           = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_WR_REQ);
      done           = (r_state == S_DONE);
      words_done     = r_words;
   end

endmodule

// File: tb/tb_mega_jsoc_mem_copy_master.sv
// tb/tb_mega_jsoc_mem_copy_master.sv - self-checking bench with memory slave model and write scoreboard
module tb_mega_jsoc_mem_copy_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len_words;
   logic        busy;
   logic        done;
   logic [15:0] words_done;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   mega_jsoc_mem_copy_master #(.ADDR_W(32), .LEN_W(16)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .src_addr          (src_addr),
      .dst_addr          (dst_addr),
      .len_words         (len_words),
      .busy              (busy),
      .done              (done),
      .words_done        (words_done),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          wpct;
      int          maxlat;
      int          exp_done;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          s_cyc = 0;
   int          wait_pct = 0;
   int          max_lat = 1;
   int          pend_cnt = 0;
   logic [31:0] pend_data = '0;
   int          n_reads = 0;
   int          n_writes = 0;
   bit          strobe_seen = 0;
   bit          prev_stall = 0;
   logic [65:0] prev_vec = '0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_rd [$];
   wr_t         exp_wr [$];
   vec_t        vecs [6];

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory slave: random stalls, variable read latency, scoreboard on every accepted transfer.
   always @(negedge clk) begin
      bit          w;
      logic [31:0] e;
      wr_t         ew;
      avm_readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt = pend_cnt - 1;
         if (pend_cnt == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pend_data;
         end
      end
      if (avm_read || avm_write) begin
         strobe_seen = 1;
         chk("rd_wr_excl", {65'd0, avm_read & avm_write}, 66'd0);
      end
      if (prev_stall && reset_n)
         chk("stall_hold", {avm_read, avm_write, avm_address, avm_writedata}, prev_vec);
      w = reset_n && (int'($urandom_range(99)) < wait_pct);
      avm_waitrequest = w;
      if (reset_n && avm_read && !w) begin
         e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hDEAD_BEEF;
         chk("rd_addr", {34'd0, avm_address}, {34'd0, e});
         pend_cnt = int'($urandom_range(max_lat, 1));
         pend_data = mem.exists(avm_address) ? mem[avm_address] : 32'h0;
         n_reads++;
      end
      if (reset_n && avm_write && !w) begin
         if (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
         end else begin
            ew.a = 32'hDEAD_BEEF;
            ew.d = 32'hDEAD_BEEF;
         end
         chk("wr_addr", {34'd0, avm_address}, {34'd0, ew.a});
         chk("wr_data", {34'd0, avm_writedata}, {34'd0, ew.d});
         mem[avm_address] = avm_writedata;
         n_writes++;
      end
      prev_stall = reset_n && (avm_read || avm_write) && w;
      prev_vec = {avm_read, avm_write, avm_address, avm_writedata};
   end

   task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input bit fixed_pat);
      logic [31:0] s;
      logic [31:0] d;
      @(negedge clk);
      s = src & 32'hFFFF_FFFC;
      d = dst & 32'hFFFF_FFFC;
      for (int i = 0; i < len; i++) begin
         wr_t ew;
         logic [31:0] v;
         v = fixed_pat ? 32'hA0 + 32'(i) : $urandom;
         mem[s] = v;
         exp_rd.push_back(s);
         ew.a = d;
         ew.d = v;
         exp_wr.push_back(ew);
         s = s + 32'd4;
         d = d + 32'd4;
      end
      n_reads = 0;
      n_writes = 0;
      strobe_seen = 0;
      src_addr = src;
      dst_addr = dst;
      len_words = 16'(len);
      start = 1'b1;
      s_cyc = cyc;
   endtask

   task automatic wait_done(input int exp_cyc, input int len);
      bit found = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            found = 1;
            break;
         end
      end
      if (!found) begin
         chk("done_timeout", 66'd0, 66'd1);
      end else begin
         if (exp_cyc >= 0) chk("done_cycle", 66'(cyc - s_cyc), 66'(exp_cyc));
         chk("busy_at_done", {65'd0, busy}, 66'd0);
         @(negedge clk);
         chk("done_pulse", {65'd0, done}, 66'd0);
         chk("words_done", {50'd0, words_done}, 66'(len));
         chk("n_reads", 66'(n_reads), 66'(len));
         chk("n_writes", 66'(n_writes), 66'(len));
         chk("wr_left", 66'(exp_wr.size()), 66'd0);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd"}, {65'd0, avm_read}, 66'd0);
      chk({tag, "_wr"}, {65'd0, avm_write}, 66'd0);
      chk({tag, "_done"}, {65'd0, done}, 66'd0);
      chk({tag, "_busy"}, {65'd0, busy}, 66'd0);
      chk({tag, "_wd"}, {50'd0, words_done}, 66'd0);
      chk({tag, "_addr"}, {34'd0, avm_address}, 66'd0);
      chk({tag, "_wdata"}, {34'd0, avm_writedata}, 66'd0);
   endtask

   initial begin
      bit hit;
      vecs[0] = '{32'h0000_0000, 32'h0000_1000, 4, 0, 1, 13};
      vecs[1] = '{32'h0000_0100, 32'h0000_2000, 0, 0, 1, 1};
      vecs[2] = '{32'h0000_0200, 32'h0000_3000, 16, 50, 3, -1};
      vecs[3] = '{32'hFFFF_FFFE, 32'h0000_4002, 2, 0, 1, 7};
      vecs[4] = '{32'h0000_0500, 32'h0000_6000, 3, 30, 2, -1};
      vecs[5] = '{32'h0000_0700, 32'h0000_7000, 1, 0, 1, 4};

      reset_n = 1'b0;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len_words = '0;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
      avm_readdatavalid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      chk("byteenable", {62'd0, avm_byteenable}, 66'hF);
      reset_n = 1'b1;

      for (int k = 0; k < 6; k++) begin
         wait_pct = vecs[k].wpct;
         max_lat = vecs[k].maxlat;
         start_copy(vecs[k].src, vecs[k].dst, vecs[k].len, k == 0);
         wait_done(vecs[k].exp_done, vecs[k].len);
         if (vecs[k].len == 0) chk("zero_no_strobe", {65'd0, strobe_seen}, 66'd0);
      end
      chk("basic_mem0", {34'd0, mem[32'h1000]}, 66'hA0);
      chk("basic_mem3", {34'd0, mem[32'h100C]}, 66'hA3);

      // Start pulse with different parameters during a copy must be ignored.
      wait_pct = 0;
      max_lat = 1;
      start_copy(32'h0000_0800, 32'h0000_8000, 6, 0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      src_addr = 32'h0000_0900;
      dst_addr = 32'h0000_9000;
      len_words = 16'd3;
      start = 1'b1;
      wait_done(19, 6);
      repeat (10) @(negedge clk);
      chk("ignored_no_strobe", {65'd0, busy | avm_read | avm_write}, 66'd0);
      chk("ignored_reads", 66'(n_reads), 66'd6);
      chk("ignored_wd", {50'd0, words_done}, 66'd6);

      // Reset while the second write of an eight-word copy is pending.
      start_copy(32'h0000_0A00, 32'h0000_A000, 8, 0);
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (avm_write && n_writes == 1) begin
            hit = 1;
            break;
         end
      end
      chk("reach_wr2", {65'd0, hit}, 66'd1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      exp_rd.delete();
      exp_wr.delete();
      repeat (2) @(negedge clk);
      chk_reset_outputs("midrst_hold");
      reset_n = 1'b1;
      start_copy(32'h0000_0C00, 32'h0000_C000, 1, 0);
      wait_done(4, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
